ahb_slave_if: RTL and testbench
===============================

Name: ahb_slave_if

Overview:
AHB-Lite slave front end that sits directly upstream of the APB controller FSM in the AHB2APB bridge.
- Qualifies AHB transfers and produces the `valid` strobe and slave select `temp_sel`.
- Builds the two-deep address/data/write pipeline (`haddr1/2`, `hwdata1/2`, `hwrite_reg/1`) that the controller consumes.
- Owns the AHB response path: a two-cycle ERROR sequence for bad transfers, otherwise passthrough of the controller's ready.
- Keeps a saturating error counter for debug.

Parameters:
- SLV0_BASE, 32'h8000_0000, base of slave 0 window
- SLV1_BASE, 32'h8400_0000, base of slave 1 window
- SLV2_BASE, 32'h8800_0000, base of slave 2 window
- WIN_SIZE, 32'h0400_0000, size of each window in bytes (power of two)
- ERR_CNT_W, 8, width of the error counter

Ports:
- hclk  in  1  bridge clock
- hreset  in  1  synchronous, active-high reset
- hwrite  in  1  AHB write
- hreadyin  in  1  AHB bus ready
- htrans  in  2  AHB transfer type
- hsize  in  3  AHB transfer size
- haddr  in  32  AHB address
- hwdata  in  32  AHB write data
- prdata  in  32  APB read data
- apb_readyout  in  1  ready from the APB controller
- valid  out  1  qualified transfer strobe to the controller
- temp_sel  out  3  one-hot slave select
- haddr1, haddr2  out  32  address pipeline stages 1 and 2
- hwdata1, hwdata2  out  32  write-data pipeline stages 1 and 2
- hwrite_reg, hwrite_reg1  out  1  hwrite pipeline stages 1 and 2
- hreadyout  out  1  AHB ready to master
- hresp  out  2  AHB response (00 OKAY, 01 ERROR)
- hrdata  out  32  AHB read data
- err_count  out  ERR_CNT_W  saturating count of ERROR responses

Behaviour:
- Clock and reset: one clock (`hclk`); reset (`hreset`) is synchronous and active-high. All registers are sampled on posedge hclk.
- Reset values: `haddr1`, `haddr2`, `hwdata1`, `hwdata2` = 0; `hwrite_reg`, `hwrite_reg1` = 0; `err_count` = 0; FSM in OKAY_ST, therefore `hreadyout` = `apb_readyout` and `hresp` = 00.
- Active transfer: `act = hreadyin & htrans[1]` (NONSEQ = 10 or SEQ = 11). IDLE (00) and BUSY (01) are never active.
- Decode (combinational):
  - `temp_sel` = 001 / 010 / 100 when `haddr` is in `[SLVn_BASE, SLVn_BASE + WIN_SIZE)`, else 000.
  - `in_map` = |`temp_sel`.
- Alignment:
  - `misal` = 1 when `hsize` > 2, or `hsize` = 1 with `haddr[0]`, or `hsize` = 2 with `haddr[1:0]` ≠ 0.
  - Byte transfers (`hsize` = 0) are always aligned.
- `bad` = `act & (!in_map | misal)`.
- `valid` = `act & in_map & !misal & (state == OKAY_ST)`. Combinational, zero latency; the controller samples it in the same cycle.
- Pipeline, enabled when `hreadyin` = 1, otherwise holds:
  - `haddr1` <= `haddr`; `haddr2` <= `haddr1`
  - `hwdata1` <= `hwdata`; `hwdata2` <= `hwdata1`
  - `hwrite_reg` <= `hwrite`; `hwrite_reg1` <= `hwrite_reg`
  - Latency is 1 and 2 cycles respectively.
- Response FSM (3 states):
  - OKAY_ST:
    - `hresp` = 00, `hreadyout` = `apb_readyout`.
    - If `bad`, go to ERR1_ST; otherwise stay.
  - ERR1_ST:
    - `hresp` = 01, `hreadyout` = 0; `err_count` increments, saturating at all-ones.
    - Always go to ERR2_ST.
  - ERR2_ST:
    - `hresp` = 01, `hreadyout` = 1.
    - Always go to OKAY_ST. Any transfer presented in this cycle is ignored (the master cancels it per AHB-Lite).
- `valid` is forced to 0 in ERR1_ST and ERR2_ST, regardless of inputs.
- `hrdata` = `prdata`, combinational passthrough.
- Boundaries and corner cases:
  - IDLE/BUSY transfers, including unmapped addresses, give OKAY with no error.
  - `hreadyin` = 0 suppresses `valid` and `bad`.
  - Back-to-back bad transfers each produce a full two-cycle ERROR; a second bad transfer seen in ERR2_ST is not counted.
  - Address `SLVn_BASE + WIN_SIZE - 1` decodes as slave n; the next byte decodes as slave n+1, or as unmapped after slave 2.
  - Reset asserted in ERR1_ST or ERR2_ST returns to OKAY_ST on the next edge; the counter clears.

Decomposition:
- Package `ahb_apb_pkg`:
  - HTRANS codes: IDLE, BUSY, NONSEQ, SEQ
  - HRESP codes: OKAY, ERROR
  - HSIZE codes
  - response-FSM state enum
  - default slave bases and window size
- Sub-module `ahb_addr_decode`: combinational `haddr` + `hsize` → `temp_sel`, `in_map`, `misal`. Reused by the bench scoreboard.
- The pipeline and the FSM stay in the top.

Test Plan:
1. Reset: hold `hreset` = 1 for 2 cycles with random inputs → all pipeline outputs 0, `hresp` = 00, `hreadyout` = `apb_readyout`, `err_count` = 0.
2. Decode: NONSEQ word write to 0x8000_0004, then NONSEQ word write to 0x8400_0010 → `valid` = 1 with `temp_sel` 001 then 010; one cycle later `haddr1` = 0x8000_0004, then 0x8400_0010 with `haddr2` = 0x8000_0004.
3. Pipeline: hold `hreadyin` = 0 for 3 cycles between two transfers → `haddr1/2`, `hwdata1/2`, `hwrite_reg/1` frozen; `valid` = 0 throughout.
4. Unmapped: NONSEQ read to 0x9000_0000 → `valid` = 0; next cycle `hresp` = 01 / `hreadyout` = 0; following cycle `hresp` = 01 / `hreadyout` = 1; then OKAY; `err_count` = 1.
5. Misaligned:
   - `hsize` = 2 at 0x8800_0002 → ERROR sequence, `err_count` +1.
   - `hsize` = 0 at 0x8800_0003 → `valid` = 1, `temp_sel` = 100.
6. Saturation and reset mid-error:
   - With ERR_CNT_W = 2, issue 5 bad transfers → `err_count` stops at 3.
   - Assert `hreset` in ERR1_ST → next cycle OKAY_ST, `hresp` = 00, `err_count` = 0.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB bridge definitions: bus encodings, response FSM states and
// default slave address map.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        OKAY_ST = 2'd0,
        ERR1_ST = 2'd1,
        ERR2_ST = 2'd2
    } resp_state_t;

    localparam logic [31:0] DEF_SLV0_BASE = 32'h8000_0000;
    localparam logic [31:0] DEF_SLV1_BASE = 32'h8400_0000;
    localparam logic [31:0] DEF_SLV2_BASE = 32'h8800_0000;
    localparam logic [31:0] DEF_WIN_SIZE  = 32'h0400_0000;

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational slave-window decode and transfer alignment check.
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] SLV0_BASE = DEF_SLV0_BASE,
    parameter logic [31:0] SLV1_BASE = DEF_SLV1_BASE,
    parameter logic [31:0] SLV2_BASE = DEF_SLV2_BASE,
    parameter logic [31:0] WIN_SIZE  = DEF_WIN_SIZE
) (
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    output logic [2:0]  temp_sel,
    output logic        in_map,
    output logic        misal
);

    logic [31:0] off0, off1, off2;

    // Unsigned offset compare covers both window bounds in one test.
    assign off0 = haddr - SLV0_BASE;
    assign off1 = haddr - SLV1_BASE;
    assign off2 = haddr - SLV2_BASE;

    assign temp_sel = {off2 < WIN_SIZE, off1 < WIN_SIZE, off0 < WIN_SIZE};
    assign in_map   = |temp_sel;

    always_comb begin
        misal = 1'b0;
        case (hsize)
            HSIZE_BYTE: misal = 1'b0;
            HSIZE_HALF: misal = haddr[0];
            HSIZE_WORD: misal = |haddr[1:0];
            default:    misal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end: transfer qualification, address/data pipeline
// and the two-cycle ERROR response sequence.
module ahb_slave_if
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] SLV0_BASE = DEF_SLV0_BASE,
    parameter logic [31:0] SLV1_BASE = DEF_SLV1_BASE,
    parameter logic [31:0] SLV2_BASE = DEF_SLV2_BASE,
    parameter logic [31:0] WIN_SIZE  = DEF_WIN_SIZE,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic                 hwrite,
    input  logic                 hreadyin,
    input  logic [1:0]           htrans,
    input  logic [2:0]           hsize,
    input  logic [31:0]          haddr,
    input  logic [31:0]          hwdata,
    input  logic [31:0]          prdata,
    input  logic                 apb_readyout,
    output logic                 valid,
    output logic [2:0]           temp_sel,
    output logic [31:0]          haddr1,
    output logic [31:0]          haddr2,
    output logic [31:0]          hwdata1,
    output logic [31:0]          hwdata2,
    output logic                 hwrite_reg,
    output logic                 hwrite_reg1,
    output logic                 hreadyout,
    output logic [1:0]           hresp,
    output logic [31:0]          hrdata,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic        act, bad, in_map, misal;
    resp_state_t state, state_nxt;

    ahb_addr_decode #(
        .SLV0_BASE(SLV0_BASE),
        .SLV1_BASE(SLV1_BASE),
        .SLV2_BASE(SLV2_BASE),
        .WIN_SIZE (WIN_SIZE)
    ) u_decode (
        .haddr   (haddr),
        .hsize   (hsize),
        .temp_sel(temp_sel),
        .in_map  (in_map),
        .misal   (misal)
    );

    assign act    = hreadyin & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
    assign bad    = act & (~in_map | misal);
    assign hrdata = prdata;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state       <= OKAY_ST;
            haddr1      <= '0;
            haddr2      <= '0;
            hwdata1     <= '0;
            hwdata2     <= '0;
            hwrite_reg  <= 1'b0;
            hwrite_reg1 <= 1'b0;
            err_count   <= '0;
        end else begin
            state <= state_nxt;
            if (hreadyin) begin
                haddr1      <= haddr;
                haddr2      <= haddr1;
                hwdata1     <= hwdata;
                hwdata2     <= hwdata1;
                hwrite_reg  <= hwrite;
                hwrite_reg1 <= hwrite_reg;
            end
            if (state == ERR1_ST && err_count != '1)
                err_count <= err_count + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        hresp     = HRESP_OKAY;
        hreadyout = apb_readyout;
        valid     = 1'b0;
        case (state)
            OKAY_ST: begin
                valid = act & in_map & ~misal;
                if (bad)
                    state_nxt = ERR1_ST;
            end
            ERR1_ST: begin
                hresp     = HRESP_ERROR;
                hreadyout = 1'b0;
                state_nxt = ERR2_ST;
            end
            ERR2_ST: begin
                // The master cancels whatever it presents here, so it is not decoded.
                hresp     = HRESP_ERROR;
                hreadyout = 1'b1;
                state_nxt = OKAY_ST;
            end
            default: state_nxt = OKAY_ST;
        endcase
    end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed table-driven bench for ahb_slave_if, with hand sequences for
// counter saturation and reset during an ERROR response.
module tb_ahb_slave_if;

    logic        hclk = 1'b0;
    logic        hreset, hwrite, hreadyin, apb_readyout;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr, hwdata, prdata;
    logic        valid, hreadyout, hwrite_reg, hwrite_reg1;
    logic [2:0]  temp_sel;
    logic [31:0] haddr1, haddr2, hwdata1, hwdata2, hrdata;
    logic [1:0]  hresp;
    logic [1:0]  err_count;

    int checks = 0;
    int errors = 0;
    int unsigned wcnt = 0;

    always #5 hclk = ~hclk;

    ahb_slave_if #(.ERR_CNT_W(2)) dut (
        .hclk(hclk), .hreset(hreset), .hwrite(hwrite), .hreadyin(hreadyin),
        .htrans(htrans), .hsize(hsize), .haddr(haddr), .hwdata(hwdata),
        .prdata(prdata), .apb_readyout(apb_readyout), .valid(valid),
        .temp_sel(temp_sel), .haddr1(haddr1), .haddr2(haddr2),
        .hwdata1(hwdata1), .hwdata2(hwdata2), .hwrite_reg(hwrite_reg),
        .hwrite_reg1(hwrite_reg1), .hreadyout(hreadyout), .hresp(hresp),
        .hrdata(hrdata), .err_count(err_count)
    );

    // Reference for the write-data / write-flag pipeline stages.
    logic [31:0] m_wd1, m_wd2;
    logic        m_wr1, m_wr2;
    always @(posedge hclk) begin
        if (hreset) begin
            m_wd1 <= '0; m_wd2 <= '0; m_wr1 <= 1'b0; m_wr2 <= 1'b0;
        end else if (hreadyin) begin
            m_wd1 <= hwdata; m_wd2 <= m_wd1; m_wr1 <= hwrite; m_wr2 <= m_wr1;
        end
    end

    typedef struct {
        logic        rdy;
        logic [1:0]  trans;
        logic [2:0]  size;
        logic [31:0] addr;
        logic        wr;
        logic        ardy;
        logic        evalid;
        logic [2:0]  esel;
        logic [1:0]  eresp;
        logic        erdy;
        logic [31:0] ea1;
        logic [31:0] ea2;
        logic [1:0]  eerr;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic rdy, logic [1:0] trans, logic [2:0] size,
                                logic [31:0] addr, logic wr, logic ardy,
                                logic ev, logic [2:0] es, logic [1:0] er,
                                logic erd, logic [31:0] a1, logic [31:0] a2,
                                logic [1:0] ee);
        vec_t v;
        v.rdy = rdy; v.trans = trans; v.size = size; v.addr = addr; v.wr = wr;
        v.ardy = ardy; v.evalid = ev; v.esel = es; v.eresp = er; v.erdy = erd;
        v.ea1 = a1; v.ea2 = a2; v.eerr = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic rdy, input logic [1:0] trans, input logic [2:0] size,
                         input logic [31:0] addr, input logic wr, input logic ardy);
        wcnt++;
        hreadyin = rdy; htrans = trans; hsize = size; haddr = addr; hwrite = wr;
        apb_readyout = ardy;
        hwdata = 32'hD000_0000 | wcnt;
        prdata = ~addr ^ wcnt;
    endtask

    task automatic chk_pipe_model(input string tag);
        chk({tag, ".hwdata1"}, hwdata1, m_wd1);
        chk({tag, ".hwdata2"}, hwdata2, m_wd2);
        chk({tag, ".hwrite_reg"}, {31'd0, hwrite_reg}, {31'd0, m_wr1});
        chk({tag, ".hwrite_reg1"}, {31'd0, hwrite_reg1}, {31'd0, m_wr2});
        chk({tag, ".hrdata"}, hrdata, prdata);
    endtask

    initial begin
        //               rdy trans  sz addr          wr ardy | v  sel     resp rdy a1            a2            err
        vecs[0]  = mk(1, 2'b10, 2, 32'h8000_0004, 1, 1, 1, 3'b001, 0, 1, 32'h0,         32'h0,         0);
        vecs[1]  = mk(1, 2'b10, 2, 32'h8400_0010, 1, 1, 1, 3'b010, 0, 1, 32'h8000_0004, 32'h0,         0);
        vecs[2]  = mk(0, 2'b10, 2, 32'h8800_0000, 0, 0, 0, 3'b100, 0, 0, 32'h8400_0010, 32'h8000_0004, 0);
        vecs[3]  = mk(0, 2'b10, 2, 32'h9000_0000, 0, 1, 0, 3'b000, 0, 1, 32'h8400_0010, 32'h8000_0004, 0);
        vecs[4]  = mk(0, 2'b10, 2, 32'h8000_0000, 0, 1, 0, 3'b001, 0, 1, 32'h8400_0010, 32'h8000_0004, 0);
        vecs[5]  = mk(1, 2'b00, 2, 32'h9000_0000, 0, 1, 0, 3'b000, 0, 1, 32'h8400_0010, 32'h8000_0004, 0);
        vecs[6]  = mk(1, 2'b01, 2, 32'h9000_0000, 0, 1, 0, 3'b000, 0, 1, 32'h9000_0000, 32'h8400_0010, 0);
        vecs[7]  = mk(1, 2'b10, 2, 32'h9000_0000, 0, 1, 0, 3'b000, 0, 1, 32'h9000_0000, 32'h9000_0000, 0);
        vecs[8]  = mk(1, 2'b00, 0, 32'h8000_0000, 0, 1, 0, 3'b001, 1, 0, 32'h9000_0000, 32'h9000_0000, 0);
        vecs[9]  = mk(1, 2'b10, 2, 32'h9000_0000, 1, 1, 0, 3'b000, 1, 1, 32'h8000_0000, 32'h9000_0000, 1);
        vecs[10] = mk(1, 2'b00, 2, 32'h8800_0002, 0, 0, 0, 3'b100, 0, 0, 32'h9000_0000, 32'h8000_0000, 1);
        vecs[11] = mk(1, 2'b10, 2, 32'h8800_0002, 1, 1, 0, 3'b100, 0, 1, 32'h8800_0002, 32'h9000_0000, 1);
        vecs[12] = mk(1, 2'b10, 0, 32'h8800_0003, 0, 1, 0, 3'b100, 1, 0, 32'h8800_0002, 32'h8800_0002, 1);
        vecs[13] = mk(1, 2'b00, 0, 32'h8800_0003, 0, 1, 0, 3'b100, 1, 1, 32'h8800_0003, 32'h8800_0002, 2);
        vecs[14] = mk(1, 2'b10, 0, 32'h8800_0003, 0, 1, 1, 3'b100, 0, 1, 32'h8800_0003, 32'h8800_0003, 2);
        vecs[15] = mk(1, 2'b11, 1, 32'h83FF_FFFE, 1, 1, 1, 3'b001, 0, 1, 32'h8800_0003, 32'h8800_0003, 2);
        vecs[16] = mk(1, 2'b11, 0, 32'h83FF_FFFF, 1, 1, 1, 3'b001, 0, 1, 32'h83FF_FFFE, 32'h8800_0003, 2);
        vecs[17] = mk(1, 2'b11, 0, 32'h8400_0000, 1, 1, 1, 3'b010, 0, 1, 32'h83FF_FFFF, 32'h83FF_FFFE, 2);
        vecs[18] = mk(1, 2'b11, 0, 32'h8BFF_FFFF, 1, 1, 1, 3'b100, 0, 1, 32'h8400_0000, 32'h83FF_FFFF, 2);
        vecs[19] = mk(1, 2'b10, 0, 32'h8C00_0000, 0, 1, 0, 3'b000, 0, 1, 32'h8BFF_FFFF, 32'h8400_0000, 2);

        // Reset with random inputs for two edges.
        hreset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom), 2'($urandom), 3'($urandom), $urandom, 1'($urandom), 1'($urandom));
            @(posedge hclk); #1;
        end
        #1;
        chk("rst.haddr1", haddr1, 32'h0);
        chk("rst.haddr2", haddr2, 32'h0);
        chk("rst.hwdata1", hwdata1, 32'h0);
        chk("rst.hwdata2", hwdata2, 32'h0);
        chk("rst.hwrite", {30'd0, hwrite_reg, hwrite_reg1}, 32'h0);
        chk("rst.hresp", {30'd0, hresp}, 32'h0);
        chk("rst.hreadyout", {31'd0, hreadyout}, {31'd0, apb_readyout});
        chk("rst.err_count", {30'd0, err_count}, 32'h0);
        hreset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            drive(vecs[i].rdy, vecs[i].trans, vecs[i].size, vecs[i].addr, vecs[i].wr, vecs[i].ardy);
            #1;
            chk({t, ".valid"}, {31'd0, valid}, {31'd0, vecs[i].evalid});
            chk({t, ".temp_sel"}, {29'd0, temp_sel}, {29'd0, vecs[i].esel});
            chk({t, ".hresp"}, {30'd0, hresp}, {30'd0, vecs[i].eresp});
            chk({t, ".hreadyout"}, {31'd0, hreadyout}, {31'd0, vecs[i].erdy});
            chk({t, ".haddr1"}, haddr1, vecs[i].ea1);
            chk({t, ".haddr2"}, haddr2, vecs[i].ea2);
            chk({t, ".err_count"}, {30'd0, err_count}, {30'd0, vecs[i].eerr});
            chk_pipe_model(t);
            @(posedge hclk); #1;
        end

        // Last vector was bad: finish its ERROR sequence; counter reaches 3.
        drive(1, 2'b00, 0, 32'h0, 0, 1); #1;
        chk("e3.err1.hresp", {30'd0, hresp}, 32'h1);
        chk("e3.err1.hreadyout", {31'd0, hreadyout}, 32'h0);
        @(posedge hclk); #1;
        chk("e3.err2.hresp", {30'd0, hresp}, 32'h1);
        chk("e3.err2.hreadyout", {31'd0, hreadyout}, 32'h1);
        chk("e3.err_count", {30'd0, err_count}, 32'h3);
        @(posedge hclk); #1;

        // Further bad transfers: halfword misaligned, then oversize; counter saturates.
        for (int k = 0; k < 3; k++) begin
            string t;
            t = $sformatf("sat%0d", k);
            if (k == 0) drive(1, 2'b10, 1, 32'h8000_0001, 0, 1);
            else        drive(1, 2'b10, 3, 32'h8000_0000, 0, 1);
            #1;
            chk({t, ".valid"}, {31'd0, valid}, 32'h0);
            chk({t, ".hresp"}, {30'd0, hresp}, 32'h0);
            @(posedge hclk); #1;
            drive(1, 2'b00, 0, 32'h0, 0, 1); #1;
            chk({t, ".err1"}, {30'd0, hresp, hreadyout}, 32'b010);
            @(posedge hclk); #1;
            chk({t, ".err2"}, {30'd0, hresp, hreadyout}, 32'b011);
            @(posedge hclk); #1;
            chk({t, ".err_count"}, {30'd0, err_count}, 32'h3);
            chk({t, ".okay"}, {30'd0, hresp}, 32'h0);
        end

        // Reset asserted while in ERR1_ST.
        drive(1, 2'b10, 2, 32'h9000_0000, 0, 1);
        @(posedge hclk); #1;
        hreset = 1'b1;
        drive(1, 2'b00, 0, 32'h0, 0, 0); #1;
        chk("rerr.pre.hresp", {30'd0, hresp}, 32'h1);
        @(posedge hclk); #1;
        chk("rerr.hresp", {30'd0, hresp}, 32'h0);
        chk("rerr.hreadyout", {31'd0, hreadyout}, 32'h0);
        chk("rerr.err_count", {30'd0, err_count}, 32'h0);
        chk("rerr.haddr1", haddr1, 32'h0);
        hreset = 1'b0;
        @(posedge hclk); #1;
        chk("rerr.after.hresp", {30'd0, hresp}, 32'h0);
        chk("rerr.after.hreadyout", {31'd0, hreadyout}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
